// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small valid/ready input FIFO.
// Bytes are sent LSB first. When more bytes are queued, frames follow each
// other with no idle gap.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_data        byte to transmit
//   i_valid       i_data valid this cycle
//   o_ready       FIFO can accept a byte (combinational !full)
//   o_tx          UART line, idle high, registered
//   o_busy        frame in progress or FIFO non-empty, registered
//   o_fifo_count  bytes currently held in the FIFO
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT    = 1042,
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int DATA_WIDTH      = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [DATA_WIDTH-1:0]      i_data,
    input  logic                       i_valid,
    output logic                       o_ready,
    output logic                       o_tx,
    output logic                       o_busy,
    output logic [FIFO_DEPTH_LOG2:0]   o_fifo_count
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0]            BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0]            IDX_LAST  = IW'(DATA_WIDTH - 1);
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_CNT  = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [DATA_WIDTH-1:0]      mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   count, count_n;
    state_t                     state, state_n;
    logic [BW-1:0]              baud, baud_n;
    logic [IW-1:0]              idx, idx_n;
    logic [DATA_WIDTH-1:0]      shift, shift_n;
    logic                       push, pop, bit_end, tx_n;

    assign o_ready      = (count != FULL_CNT);
    assign push         = i_valid & o_ready;
    assign bit_end      = (baud == BAUD_LAST);
    assign o_fifo_count = count;

    // FIFO storage: no reset needed, pointers/count define validity
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= i_data;
    end

    always_comb begin
        count_n = count;
        case ({push, pop})
            2'b10:   count_n = count + 1'b1;
            2'b01:   count_n = count - 1'b1;
            default: count_n = count;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_n;
        end
    end

    // Next-state logic. A pop only happens on entry to START, either from
    // IDLE or straight out of the last stop-bit cycle.
    always_comb begin
        state_n = state;
        baud_n  = baud + 1'b1;
        idx_n   = idx;
        shift_n = shift;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                baud_n = '0;
                if (count != '0) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_n  = '0;
                    idx_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_n  = '0;
                    shift_n = shift >> 1;
                    if (idx == IDX_LAST) state_n = STOP;
                    else                 idx_n   = idx + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_n = '0;
                    if (count != '0) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Line level is derived from the next state so o_tx can be a flop
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            baud   <= '0;
            idx    <= '0;
            shift  <= '0;
            o_tx   <= 1'b1;
            o_busy <= 1'b0;
        end else begin
            state  <= state_n;
            baud   <= baud_n;
            idx    <= idx_n;
            shift  <= shift_n;
            o_tx   <= tx_n;
            o_busy <= (state_n != IDLE) || (count_n != '0);
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int C4 = 4;
    localparam int CD = 1042;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d4, dd;
    logic       v4, vd;
    logic       ready4, tx4, busy4, readyd, txd, busyd;
    logic [2:0] count4, countd;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    uart_tx_fifo #(.CLKS_PER_BIT(C4), .FIFO_DEPTH_LOG2(2), .DATA_WIDTH(8)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(d4), .i_valid(v4),
        .o_ready(ready4), .o_tx(tx4), .o_busy(busy4), .o_fifo_count(count4));

    uart_tx_fifo #(.CLKS_PER_BIT(CD), .FIFO_DEPTH_LOG2(2), .DATA_WIDTH(8)) dutd (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(dd), .i_valid(vd),
        .o_ready(readyd), .o_tx(txd), .o_busy(busyd), .o_fifo_count(countd));

    always #50 clk = ~clk;  // 10 MHz

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model of the C4 instance: a byte queue plus "cycles left in
    // the current frame". Line level follows from the position in the frame.
    initial begin : model
        logic [7:0] q[$];
        logic [7:0] cur;
        int         rem;
        int         k;
        logic       etx;
        bit         pp, ps;
        rem = 0;
        cur = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                rem = 0;
            end else begin
                if (rem == 0) etx = 1'b1;
                else begin
                    k = 10 * C4 - rem;
                    if (k / C4 == 0)      etx = 1'b0;
                    else if (k / C4 == 9) etx = 1'b1;
                    else                  etx = cur[k / C4 - 1];
                end
                chk("mdl_tx", tx4, etx);
                chk("mdl_count", count4, q.size());
                chk("mdl_ready", ready4, q.size() < 4);
                chk("mdl_busy", busy4, (rem > 0) || (q.size() > 0));
                pp = (q.size() > 0) && (rem <= 1);
                ps = v4 && (q.size() < 4);
                if (pp) begin
                    cur = q.pop_front();
                    rem = 10 * C4;
                end else if (rem > 0) begin
                    rem--;
                end
                if (ps) q.push_back(d4);
            end
        end
    end

    // Mid-bit sampling receiver on the C4 line
    task automatic rx4(output logic [7:0] b, output int t_start, output bit ok);
        bit got_start;
        got_start = 0;
        ok = 0;
        b = 8'h00;
        t_start = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx4 === 1'b0) begin
                got_start = 1;
                break;
            end
        end
        if (got_start) begin
            ok = 1;
            t_start = cyc;
            for (int off = 1; off <= 9 * C4 + C4 / 2; off++) begin
                @(negedge clk);
                if (off % C4 == C4 / 2) begin
                    if (off / C4 == 0) begin
                        if (tx4 !== 1'b0) ok = 0;
                    end else if (off / C4 == 9) begin
                        if (tx4 !== 1'b1) ok = 0;
                    end else begin
                        b[off / C4 - 1] = tx4;
                    end
                end
            end
        end
    endtask

    task automatic wait_idle(input string name);
        bit idle;
        idle = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (busy4 === 1'b0) begin
                idle = 1;
                break;
            end
        end
        chk(name, idle, 1'b1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;  // {stop, data[7:0], start}
    } vec_t;

    vec_t       tbl[5];
    logic [7:0] rb;
    int         ts, tprev, stall, lat, w, fr;
    bit         ok, found;
    logic       samp[11000];
    logic       bsy[11000];

    initial begin
        tbl[0] = '{8'h55, 10'b1010101010};
        tbl[1] = '{8'h00, 10'b1000000000};
        tbl[2] = '{8'hFF, 10'b1111111110};
        tbl[3] = '{8'hA3, 10'b1101000110};
        tbl[4] = '{8'h80, 10'b1100000000};

        rst_n = 1'b0;
        v4 = 1'b0; vd = 1'b0; d4 = 8'h00; dd = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", tx4, 1'b1);
        chk("rst_ready", ready4, 1'b1);
        chk("rst_busy", busy4, 1'b0);
        chk("rst_count", count4, 3'd0);
        chk("rst_tx_def", txd, 1'b1);
        chk("rst_ready_def", readyd, 1'b1);
        chk("rst_busy_def", busyd, 1'b0);
        chk("rst_count_def", countd, 3'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single frames from idle, checked bit cell by bit cell
        for (int t = 0; t < 5; t++) begin
            wait_idle("tbl_idle");
            @(posedge clk); #1;
            v4 = 1'b1; d4 = tbl[t].data;
            @(posedge clk); #1;
            v4 = 1'b0;
            @(negedge clk);
            chk("tbl_tx_after_push", tx4, 1'b1);
            chk("tbl_count_after_push", count4, 3'd1);
            chk("tbl_busy_after_push", busy4, 1'b1);
            for (int j = 0; j < 10 * C4; j++) begin
                @(negedge clk);
                chk("tbl_bit", tx4, tbl[t].frame[j / C4]);
                if (j == 10 * C4 - 1) chk("tbl_busy_in_stop", busy4, 1'b1);
            end
            @(negedge clk);
            chk("tbl_busy_drop", busy4, 1'b0);
        end

        // Burst 0x01..0x06 with valid held high
        wait_idle("burst_idle");
        @(posedge clk); #1;
        fork
            begin : burst_drv
                int  k;
                bit  acc;
                k = 1;
                stall = 0;
                for (int it = 0; it < 300 && k <= 6; it++) begin
                    v4 = 1'b1; d4 = 8'(k);
                    @(negedge clk);
                    acc = ready4;
                    if (k == 6 && !acc) begin
                        stall++;
                        if (stall == 1) begin
                            chk("burst_count_full", count4, 3'd4);
                            chk("burst_ready_full", ready4, 1'b0);
                        end
                    end
                    @(posedge clk); #1;
                    if (acc) k++;
                end
                v4 = 1'b0;
                chk("burst_all_accepted", k, 7);
                chk("burst_stall_cycles", stall, 37);
            end
            begin : burst_rx
                tprev = 0;
                for (int f = 0; f < 6; f++) begin
                    rx4(rb, ts, ok);
                    chk("burst_frame_ok", ok, 1'b1);
                    chk("burst_data", rb, 8'(f + 1));
                    if (f > 0) chk("burst_no_gap", ts - tprev, 10 * C4);
                    tprev = ts;
                end
            end
        join

        // Push on the edge the stop bit ends while two bytes are queued
        wait_idle("pp_idle");
        @(posedge clk); #1;
        v4 = 1'b1; d4 = 8'h3C;
        @(posedge clk); #1;
        d4 = 8'hC5;
        @(posedge clk); #1;   // 0x3C popped on this edge
        d4 = 8'h7E;
        @(posedge clk); #1;
        v4 = 1'b0;
        chk("pp_count_setup", count4, 3'd2);
        repeat (38) @(posedge clk);
        #1;
        v4 = 1'b1; d4 = 8'h99;
        @(negedge clk);
        chk("pp_count_before", count4, 3'd2);
        @(posedge clk); #1;
        v4 = 1'b0;
        chk("pp_count_after", count4, 3'd2);
        rx4(rb, ts, ok); chk("pp_ok0", ok, 1'b1); chk("pp_data0", rb, 8'hC5);
        rx4(rb, ts, ok); chk("pp_ok1", ok, 1'b1); chk("pp_data1", rb, 8'h7E);
        rx4(rb, ts, ok); chk("pp_ok2", ok, 1'b1); chk("pp_data2", rb, 8'h99);

        // Reset during data bit 3 of 0xA3 with two bytes queued
        wait_idle("rst_idle");
        @(posedge clk); #1;
        v4 = 1'b1; d4 = 8'hA3;
        @(posedge clk); #1;
        d4 = 8'h11;
        @(posedge clk); #1;   // 0xA3 enters START here
        d4 = 8'h22;
        @(posedge clk); #1;
        v4 = 1'b0;
        repeat (16) @(posedge clk);
        #20;
        chk("midrst_pre_tx", tx4, 1'b0);
        chk("midrst_pre_count", count4, 3'd2);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", tx4, 1'b1);
        chk("midrst_count", count4, 3'd0);
        chk("midrst_ready", ready4, 1'b1);
        chk("midrst_busy", busy4, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("midrst_quiet_tx", tx4, 1'b1);
            chk("midrst_quiet_busy", busy4, 1'b0);
        end
        @(posedge clk); #1;
        v4 = 1'b1; d4 = 8'h5A;
        @(posedge clk); #1;
        v4 = 1'b0;
        rx4(rb, ts, ok);
        chk("midrst_after_ok", ok, 1'b1);
        chk("midrst_after_data", rb, 8'h5A);

        // Randomized traffic against the model
        wait_idle("rnd_idle");
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            v4 = ($urandom_range(0, 3) == 0);
            d4 = 8'($urandom());
        end
        @(posedge clk); #1;
        v4 = 1'b0;
        wait_idle("rnd_drain");

        // Default bit rate: 0xC3 on the 1042-cycle instance
        @(posedge clk); #1;
        vd = 1'b1; dd = 8'hC3;
        @(posedge clk); #1;
        vd = 1'b0;
        found = 0;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (txd === 1'b0) begin
                found = 1;
                break;
            end
        end
        chk("def_start_found", found, 1'b1);
        chk("def_latency", lat, 2);
        samp[0] = txd;
        bsy[0]  = busyd;
        for (int i = 1; i < 11000; i++) begin
            @(negedge clk);
            samp[i] = txd;
            bsy[i]  = busyd;
        end
        w = 0;
        while (w < 11000 && samp[w] === 1'b0) w++;
        chk("def_start_width", w, CD);
        fr = 0;
        while (fr < 11000 && bsy[fr] === 1'b1) fr++;
        chk("def_frame_len", fr, 10 * CD);
        for (int b = 0; b < 8; b++) rb[b] = samp[(b + 1) * CD + CD / 2];
        chk("def_rx_start", samp[CD / 2], 1'b0);
        chk("def_rx_stop", samp[9 * CD + CD / 2], 1'b1);
        chk("def_rx_data", rb, 8'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
